// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_master_pkg
// Brief    : Shared state encoding, TX source selects and phase-order helper.
// Revision : 1.0
// ============================================================================
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_ADDR     = 3'd3,
    ST_DUMMY    = 3'd4,
    ST_DATA_TX  = 3'd5,
    ST_DATA_RX  = 3'd6,
    ST_CS_HOLD  = 3'd7
  } state_e;

  localparam logic [1:0] TX_SEL_CMD  = 2'd0;
  localparam logic [1:0] TX_SEL_ADDR = 2'd1;
  localparam logic [1:0] TX_SEL_FIFO = 2'd2;

  // nz = {rx, tx, dummy, addr, cmd} non-empty flags; phase i encodes as state i+2.
  function automatic state_e next_phase(input state_e cur, input logic [4:0] nz);
    logic [2:0] cand;
    next_phase = ST_CS_HOLD;
    for (int i = 4; i >= 0; i--) begin
      cand = 3'(i + 2);
      if (nz[i] && (cand > cur)) next_phase = state_e'(cand);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : CMD/ADDR/DUMMY/DATA transaction sequencer for the APB SPI master.
// Revision : 1.0
// ============================================================================
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int CS_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_go,
  input  logic [CS_NUM-1:0] spi_csreg,
  input  logic              en_quad,
  input  logic [5:0]        cmd_len,
  input  logic [5:0]        addr_len,
  input  logic [CNT_W-1:0]  dummy_len,
  input  logic [CNT_W-1:0]  tx_len,
  input  logic [CNT_W-1:0]  rx_len,
  input  logic [31:0]       cmd,
  input  logic [31:0]       addr,
  input  logic              spi_rise,
  input  logic              spi_fall,
  output logic              spi_clk_en,
  output logic [CS_NUM-1:0] spi_csn,
  output logic              tx_start,
  output logic [1:0]        tx_sel,
  output logic [CNT_W-1:0]  tx_len_o,
  output logic              tx_quad,
  input  logic              tx_done,
  input  logic              tx_clk_en,
  output logic              rx_en,
  output logic [CNT_W-1:0]  rx_counter,
  output logic              rx_counter_upd,
  input  logic              rx_done,
  input  logic              rx_clk_en,
  output logic              busy,
  output logic              eot
);

  state_e            state_q, state_d;
  logic [CS_NUM-1:0] cs_q;
  logic              quad_q;
  logic [5:0]        cmd_len_q, addr_len_q;
  logic [CNT_W-1:0]  dummy_len_q, tx_len_q, rx_len_q;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              tx_start_q, tx_start_d;
  logic [1:0]        tx_sel_q, tx_sel_d;
  logic [CNT_W-1:0]  tx_len_o_q, tx_len_o_d;
  logic              tx_quad_q, tx_quad_d;
  logic [CNT_W-1:0]  rx_counter_q, rx_counter_d;
  logic              rx_upd_q, rx_upd_d;
  logic              eot_q, eot_d;
  logic [4:0]        nz;
  logic              go_accept;
  logic              in_phase;
  logic              unused_in;

  // Word data reaches the TX shifter through tx_sel; spi_rise only paces RX sampling.
  assign unused_in = ^{cmd, addr, spi_rise};

  assign nz        = {rx_len_q != '0, tx_len_q != '0, dummy_len_q != '0,
                      addr_len_q != '0, cmd_len_q != '0};
  assign go_accept = (state_q == ST_IDLE) && spi_go;

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    tx_start_d   = 1'b0;
    tx_sel_d     = tx_sel_q;
    tx_len_o_d   = tx_len_o_q;
    tx_quad_d    = tx_quad_q;
    rx_counter_d = rx_counter_q;
    rx_upd_d     = 1'b0;
    eot_d        = 1'b0;

    case (state_q)
      ST_IDLE:     if (spi_go) state_d = ST_CS_SETUP;
      ST_CS_SETUP: state_d = next_phase(state_q, nz);
      ST_CMD, ST_ADDR, ST_DATA_TX: if (tx_done) state_d = next_phase(state_q, nz);
      ST_DUMMY: begin
        if (spi_fall) begin
          if (dcnt_q == dummy_len_q - 1'b1) state_d = next_phase(state_q, nz);
          else                              dcnt_d  = dcnt_q + 1'b1;
        end
      end
      ST_DATA_RX:  if (rx_done) state_d = next_phase(state_q, nz);
      ST_CS_HOLD: begin
        state_d = ST_IDLE;
        eot_d   = 1'b1;
      end
      default:     state_d = ST_IDLE;
    endcase

    // Phase-entry strobes are registered so they line up with the first cycle of the phase.
    if (state_d != state_q) begin
      case (state_d)
        ST_CMD: begin
          tx_start_d = 1'b1;
          tx_sel_d   = TX_SEL_CMD;
          tx_len_o_d = CNT_W'(cmd_len_q);
          tx_quad_d  = 1'b0;
        end
        ST_ADDR: begin
          tx_start_d = 1'b1;
          tx_sel_d   = TX_SEL_ADDR;
          tx_len_o_d = CNT_W'(addr_len_q);
          tx_quad_d  = quad_q;
        end
        ST_DATA_TX: begin
          tx_start_d = 1'b1;
          tx_sel_d   = TX_SEL_FIFO;
          tx_len_o_d = tx_len_q;
          tx_quad_d  = quad_q;
        end
        ST_DUMMY:   dcnt_d = '0;
        ST_DATA_RX: begin
          rx_upd_d     = 1'b1;
          rx_counter_d = rx_len_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cs_q         <= '0;
      quad_q       <= 1'b0;
      cmd_len_q    <= '0;
      addr_len_q   <= '0;
      dummy_len_q  <= '0;
      tx_len_q     <= '0;
      rx_len_q     <= '0;
      dcnt_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_sel_q     <= '0;
      tx_len_o_q   <= '0;
      tx_quad_q    <= 1'b0;
      rx_counter_q <= '0;
      rx_upd_q     <= 1'b0;
      eot_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      tx_start_q   <= tx_start_d;
      tx_sel_q     <= tx_sel_d;
      tx_len_o_q   <= tx_len_o_d;
      tx_quad_q    <= tx_quad_d;
      rx_counter_q <= rx_counter_d;
      rx_upd_q     <= rx_upd_d;
      eot_q        <= eot_d;
      if (go_accept) begin
        cs_q        <= spi_csreg;
        quad_q      <= en_quad;
        cmd_len_q   <= cmd_len;
        addr_len_q  <= addr_len;
        dummy_len_q <= dummy_len;
        tx_len_q    <= tx_len;
        rx_len_q    <= rx_len;
      end
    end
  end

  assign in_phase       = (state_q != ST_IDLE) && (state_q != ST_CS_SETUP) &&
                          (state_q != ST_CS_HOLD);
  assign spi_clk_en     = in_phase && (tx_clk_en || rx_clk_en || (state_q == ST_DUMMY));
  assign busy           = (state_q != ST_IDLE);
  assign spi_csn        = busy ? ~cs_q : '1;
  assign tx_start       = tx_start_q;
  assign tx_sel         = tx_sel_q;
  assign tx_len_o       = tx_len_o_q;
  assign tx_quad        = tx_quad_q;
  assign rx_en          = (state_q == ST_DATA_RX) && !rx_upd_q;
  assign rx_counter     = rx_counter_q;
  assign rx_counter_upd = rx_upd_q;
  assign eot            = eot_q;

endmodule
`default_nettype wire
